// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the switch/button input conditioner: debounce cell state
// encodings and default timing constants for the 50 MHz board clock.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } db_state_e;

  // 10 ms of stable input at 50 MHz before a level change is accepted
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_CNT_W           = 20;
  // 0.5 s auto-repeat period at 50 MHz
  localparam int unsigned DEF_REPEAT_CYCLES   = 25000000;

endpackage

// File: rtl/input_conditioner_debounce_cell.sv
// One debounce channel: 2-flop synchroniser followed by a four-state debounce FSM.
// The level output changes only when the synchronised input has held for DEBOUNCE_CYCLES.
module debounce_cell
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             sample;

  assign sample = sync_q[1];
  assign level  = level_q;

  always_comb begin
    sync_d  = {sync_q[0], din};
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      STABLE_LO: begin
        if (sample) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!sample) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          level_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!sample) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (sample) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Switch/button front end: debounced switch level, one-cycle step per button press and a
// wrapping press counter. Define AUTO_REPEAT_EN to add periodic steps while the button is held.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_raw,
  input  logic       btn_raw,
  output logic       in_clean,
  output logic       btn_level,
  output logic       step,
  output logic [7:0] press_count
);

  logic       btn_norm;
  logic       btn_prev_q, btn_prev_d;
  logic       step_q, step_d;
  logic [7:0] press_count_q, press_count_d;
  logic       press_edge;
  logic       rep_fire;

  // Normalise before synchronising so both cells see 1 = active
  assign btn_norm = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

  debounce_cell #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_sw_cell (
    .clk  (clk),
    .rst_n(reset),
    .din  (sw_raw),
    .level(in_clean)
  );

  debounce_cell #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn_cell (
    .clk  (clk),
    .rst_n(reset),
    .din  (btn_norm),
    .level(btn_level)
  );

  assign press_edge = btn_level & ~btn_prev_q;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned      REP_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_q, rep_d;

  // Timer restarts with the press step so repeats land every REPEAT_CYCLES after it
  always_comb begin
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (!btn_level || press_edge) begin
      rep_d = '0;
    end else if (rep_q == REP_LAST) begin
      rep_d    = '0;
      rep_fire = 1'b1;
    end else begin
      rep_d = rep_q + REP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  logic unused_repeat;

  assign rep_fire      = 1'b0;
  assign unused_repeat = ^REPEAT_CYCLES;
`endif

  always_comb begin
    btn_prev_d    = btn_level;
    step_d        = press_edge | rep_fire;
    press_count_d = press_count_q + {7'd0, step_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_prev_q    <= 1'b0;
      step_q        <= 1'b0;
      press_count_q <= '0;
    end else begin
      btn_prev_q    <= btn_prev_d;
      step_q        <= step_d;
      press_count_q <= press_count_d;
    end
  end

  assign step        = step_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4, CNT_W=3, REPEAT_CYCLES=8, active-low button.
// Define AUTO_REPEAT_EN for both bench and RTL to exercise the auto-repeat build.
`timescale 1ns/1ps
module tb_input_conditioner;

  localparam int unsigned N        = 4;
  localparam int unsigned R        = 8;
  localparam logic        PRESSED  = 1'b0;
  localparam logic        RELEASED = 1'b1;
`ifdef AUTO_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       sw_raw  = 1'b0;
  logic       btn_raw = RELEASED;
  logic       in_clean, btn_level, step;
  logic [7:0] press_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  input_conditioner #(
    .DEBOUNCE_CYCLES(N),
    .CNT_W          (3),
    .BTN_ACTIVE_LOW (1'b1),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .btn_raw    (btn_raw),
    .in_clean   (in_clean),
    .btn_level  (btn_level),
    .step       (step),
    .press_count(press_count)
  );

  // Reference model: a level flips once N+1 consecutive synchronised samples agree on the
  // new value; samples reach the debouncer two edges after capture. Steps follow the rise.
  bit          q_sw[$]  = '{1'b0, 1'b0};
  bit          q_btn[$] = '{1'b0, 1'b0};
  bit          rv_sw = 1'b0, rv_btn = 1'b0, s_sw, s_btn;
  int unsigned run_sw = 0, run_btn = 0;
  bit          m_in_clean = 1'b0, m_btn_level = 1'b0, m_step = 1'b0;
  logic [7:0]  m_count = 8'd0;
  int unsigned edge_n = 0, rise_edge = 0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      q_sw = '{1'b0, 1'b0};
      q_btn = '{1'b0, 1'b0};
      rv_sw = 1'b0; rv_btn = 1'b0; run_sw = 0; run_btn = 0;
      m_in_clean = 1'b0; m_btn_level = 1'b0; m_step = 1'b0; m_count = 8'd0;
      edge_n = 0; rise_edge = 0;
    end else begin
      edge_n++;
      if (REPEAT_ON) m_step = m_btn_level && (((edge_n - rise_edge - 1) % R) == 0);
      else           m_step = m_btn_level && (edge_n == rise_edge + 1);
      if (m_step) m_count++;
      q_sw.push_back(sw_raw);
      q_btn.push_back(~btn_raw);
      s_sw  = q_sw.pop_front();
      s_btn = q_btn.pop_front();
      if (s_sw == rv_sw) run_sw++; else begin rv_sw = s_sw; run_sw = 1; end
      if (s_btn == rv_btn) run_btn++; else begin rv_btn = s_btn; run_btn = 1; end
      if (run_sw >= N + 1) m_in_clean = rv_sw;
      if (run_btn >= N + 1 && rv_btn != m_btn_level) begin
        m_btn_level = rv_btn;
        if (rv_btn) rise_edge = edge_n;
      end
    end
  end

  // Edge numbering in the directed tests: i=1 is the first edge that captures the new raw value.
  task automatic test_reset();
    logic [10:0] got, exp;
    reset = 1'b0; sw_raw = 1'b1; btn_raw = PRESSED;
    repeat (3) @(posedge clk);
    #1;
    got = {in_clean, btn_level, step, press_count};
    n_cmp++;
    if (got !== 11'h000) begin n_bad++; $display("FAIL reset_hold got=%h exp=%h", got, 11'h000); end
    reset = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if (i == 9) btn_raw = RELEASED;
      @(posedge clk); #1;
      got = {in_clean, btn_level, step, press_count};
      exp = {i >= 7, i >= 7, i == 8, (i >= 8) ? 8'd1 : 8'd0};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL reset_release i=%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_switch_latency();
    logic tgt;
    for (int t = 0; t < 2; t++) begin
      tgt = (t == 1);
      sw_raw = tgt;
      for (int i = 1; i <= 8; i++) begin
        @(posedge clk); #1;
        n_cmp++;
        if (in_clean !== ((i >= 7) ? tgt : ~tgt)) begin
          n_bad++; $display("FAIL sw_latency tgt=%0b i=%0d got=%b exp=%b", tgt, i, in_clean, (i >= 7) ? tgt : ~tgt);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic pat [17];
    logic [9:0] got;
    for (int k = 0; k < 17; k++) pat[k] = (k < 3 || (k >= 4 && k < 7)) ? PRESSED : RELEASED;
    for (int k = 0; k < 17; k++) begin
      btn_raw = pat[k];
      @(posedge clk); #1;
      got = {btn_level, step, press_count};
      n_cmp++;
      if (got !== {2'b00, 8'd1}) begin n_bad++; $display("FAIL bounce k=%0d got=%h exp=%h", k, got, {2'b00, 8'd1}); end
    end
  endtask

  task automatic test_presses();
    int unsigned hi_steps, lo_steps;
    logic [7:0] exp_cnt;
    reset = 1'b0; btn_raw = RELEASED;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int p = 0; p < 256; p++) begin
      hi_steps = 0; lo_steps = 0;
      btn_raw = PRESSED;
      repeat (8) begin @(posedge clk); #1; if (step) hi_steps++; end
      btn_raw = RELEASED;
      repeat (8) begin @(posedge clk); #1; if (step) lo_steps++; end
      if (p < 10) begin
        n_cmp++;
        if (hi_steps != 1) begin n_bad++; $display("FAIL press_steps p=%0d got=%0d exp=1", p, hi_steps); end
        n_cmp++;
        if (lo_steps != 0) begin n_bad++; $display("FAIL release_steps p=%0d got=%0d exp=0", p, lo_steps); end
      end
      if (p == 9 || p == 254 || p == 255) begin
        exp_cnt = 8'((p + 1) % 256);
        n_cmp++;
        if (press_count !== exp_cnt) begin n_bad++; $display("FAIL press_count p=%0d got=%0d exp=%0d", p, press_count, exp_cnt); end
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [10:0] got, exp;
    btn_raw = PRESSED;
    repeat (8) begin @(posedge clk); #1; end
    btn_raw = RELEASED;
    repeat (8) begin @(posedge clk); #1; end
    n_cmp++;
    if (press_count !== 8'd1) begin n_bad++; $display("FAIL midreset_pre got=%0d exp=1", press_count); end
    btn_raw = PRESSED;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      got = {in_clean, btn_level, step, press_count};
      n_cmp++;
      if (got !== 11'h000) begin n_bad++; $display("FAIL midreset_hold k=%0d got=%h exp=%h", k, got, 11'h000); end
    end
    reset = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if (i == 9) btn_raw = RELEASED;
      @(posedge clk); #1;
      got = {in_clean, btn_level, step, press_count};
      exp = {i >= 7, i >= 7, i == 8, (i >= 8) ? 8'd1 : 8'd0};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL midreset_restart i=%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] got, exp;
    sw_raw = 1'b0; btn_raw = RELEASED;
    repeat (16) @(posedge clk);
    #1;
    sw_raw = 1'b1; btn_raw = PRESSED;
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) btn_raw = RELEASED;
      @(posedge clk); #1;
      got = {in_clean, btn_level};
      exp = {i >= 7, i >= 7};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL simultaneous i=%0d got=%b exp=%b", i, got, exp); end
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  // Level high over edges 7..36 (falls at 37); repeats may fire up to and including edge 37.
  task automatic test_repeat();
    logic [1:0] got, exp;
    logic       exp_step;
    reset = 1'b0; btn_raw = RELEASED;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      btn_raw = (i <= 30) ? PRESSED : RELEASED;
      @(posedge clk); #1;
      if (REPEAT_ON) exp_step = (i >= 8 && i <= 37 && ((i - 8) % R) == 0);
      else           exp_step = (i == 8);
      got = {btn_level, step};
      exp = {(i >= 7 && i < 37), exp_step};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL repeat i=%0d got=%b exp=%b", i, got, exp); end
    end
    n_cmp++;
    if (press_count !== (REPEAT_ON ? 8'd4 : 8'd1)) begin
      n_bad++; $display("FAIL repeat_count got=%0d exp=%0d", press_count, REPEAT_ON ? 4 : 1);
    end
  endtask

  task automatic test_random();
    int unsigned sw_left = 0, btn_left = 0;
    logic [10:0] got, exp;
    for (int c = 0; c < 1500; c++) begin
      if (sw_left == 0) begin sw_raw = 1'($urandom_range(0, 1)); sw_left = $urandom_range(1, 9); end
      if (btn_left == 0) begin btn_raw = 1'($urandom_range(0, 1)); btn_left = $urandom_range(1, 9); end
      sw_left--; btn_left--;
      reset = ($urandom_range(0, 249) != 0);
      @(posedge clk); #1;
      got = {in_clean, btn_level, step, press_count};
      exp = {m_in_clean, m_btn_level, m_step, m_count};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL random c=%0d got=%h exp=%h", c, got, exp); end
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_switch_latency();
    test_bounce();
    test_presses();
    test_reset_mid_count();
    test_simultaneous();
    test_repeat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
